// File: rtl/frame_scan_controller_pkg.sv
// Shared definitions for the frame scan controller: state encoding,
// default timing constants and counter widths.
package frame_scan_controller_pkg;

  localparam int DLY_W = 9;
  localparam int ROW_W = 10;
  localparam int COL_W = 11;

  localparam int START_DELAY_DEF = 100;
  localparam int HSYNC_DELAY_DEF = 160;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Terminal count for a dwell of 'delay' cycles (counter runs 0..delay-1).
  function automatic logic [DLY_W-1:0] dly_term(input int delay);
    return DLY_W'(delay - 1);
  endfunction

endpackage

// File: rtl/frame_scan_controller_scan_delay_counter.sv
// Terminal-count dwell counter shared by the VSYNC and HSYNC phases.
// o_tc is high in the last cycle of the dwell; the count then wraps to 0.
module scan_delay_counter
  import frame_scan_controller_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DLY_W-1:0] i_term,
  output logic             o_tc
);

  logic [DLY_W-1:0] r_cnt;

  assign o_tc = i_en & (r_cnt == i_term);

  // Count while enabled; restart from 0 on clear or on reaching the terminal value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= {DLY_W{1'b0}};
    end else if (i_clr | o_tc) begin
      r_cnt <= {DLY_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + DLY_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/frame_scan_controller.sv
// Frame scan controller: start delay, per-line blanking and active-data
// sequencing for one frame, one read address per even/odd pixel pair with
// downstream backpressure.
// Optional build macro FRAME_SCAN_ROW_FLIP_EN: addresses are generated
// bottom-up (row_src = IMAGE_HEIGHT-1-row) for BMP-ordered storage; the
// row/column outputs keep counting top-down.
module frame_scan_controller
  import frame_scan_controller_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int START_DELAY  = START_DELAY_DEF,
  parameter int HSYNC_DELAY  = HSYNC_DELAY_DEF,
  parameter int ADDR_W       = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [9:0]        row,
  output logic [10:0]       column,
  output logic              vertical_Pulse,
  output logic              horizontal_Pulse,
  output logic              busy,
  output logic              sig_done
);

  localparam logic [DLY_W-1:0]  LP_START_TERM = dly_term(START_DELAY);
  localparam logic [DLY_W-1:0]  LP_HSYNC_TERM = dly_term(HSYNC_DELAY);
  localparam logic [COL_W-1:0]  LP_COL_LAST   = COL_W'(IMAGE_WIDTH - 2);
  localparam logic [ROW_W-1:0]  LP_ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LP_WIDTH      = ADDR_W'(IMAGE_WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [ROW_W-1:0]   r_row;
  logic [ROW_W-1:0]   w_row_nxt;
  logic [COL_W-1:0]   r_col;
  logic [COL_W-1:0]   w_col_nxt;
  logic [ROW_W-1:0]   w_row_src;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               w_cnt_en;
  logic               w_cnt_clr;
  logic [DLY_W-1:0]   w_term;
  logic               w_tc;
  logic               r_rd_valid;
  logic               r_vpulse;
  logic               r_hpulse;
  logic               r_busy;
  logic               r_done;

  scan_delay_counter u_dly (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .i_term  (w_term),
    .o_tc    (w_tc)
  );

  // Next-state, next row/column and dwell-counter control.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_term      = LP_HSYNC_TERM;
    case (r_state)
      ST_IDLE: begin
        w_row_nxt = {ROW_W{1'b0}};
        w_col_nxt = {COL_W{1'b0}};
        w_cnt_clr = 1'b1;
        if (start) begin
          w_state_nxt = ST_VSYNC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        w_cnt_en = 1'b1;
        w_term   = LP_START_TERM;
        if (w_tc) begin
          w_state_nxt = ST_HSYNC;
        end else begin
          w_state_nxt = ST_VSYNC;
        end
      end
      ST_HSYNC: begin
        w_cnt_en = 1'b1;
        w_term   = LP_HSYNC_TERM;
        if (w_tc) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_HSYNC;
        end
      end
      ST_DATA: begin
        // In DATA rd_valid is high, so a beat is simply rd_ready.
        if (rd_ready) begin
          if (r_col == LP_COL_LAST) begin
            if (r_row == LP_ROW_LAST) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_col_nxt   = {COL_W{1'b0}};
              w_row_nxt   = r_row + ROW_W'(1);
              w_state_nxt = ST_HSYNC;
            end
          end else begin
            w_col_nxt = r_col + COL_W'(2);
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DONE: begin
        w_row_nxt   = {ROW_W{1'b0}};
        w_col_nxt   = {COL_W{1'b0}};
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_row_nxt   = {ROW_W{1'b0}};
        w_col_nxt   = {COL_W{1'b0}};
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Source row for the address: straight raster or bottom-up storage.
  always_comb begin
`ifdef FRAME_SCAN_ROW_FLIP_EN
    w_row_src = LP_ROW_LAST - w_row_nxt;
`else
    w_row_src = w_row_nxt;
`endif
    if (w_state_nxt == ST_DATA) begin
      w_addr_nxt = (ADDR_W'(w_row_src) * LP_WIDTH) + ADDR_W'(w_col_nxt);
    end else begin
      w_addr_nxt = {ADDR_W{1'b0}};
    end
  end

  // State, position and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= {ROW_W{1'b0}};
      r_col   <= {COL_W{1'b0}};
      r_addr  <= {ADDR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Status flags registered from the next-state decode so they track r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_vpulse   <= 1'b0;
      r_hpulse   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= (w_state_nxt == ST_DATA);
      r_vpulse   <= (w_state_nxt == ST_HSYNC) | (w_state_nxt == ST_DATA);
      r_hpulse   <= (w_state_nxt == ST_DATA);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  assign rd_valid         = r_rd_valid;
  assign rd_addr          = r_addr;
  assign row              = r_row;
  assign column           = r_col;
  assign vertical_Pulse   = r_vpulse;
  assign horizontal_Pulse = r_hpulse;
  assign busy             = r_busy;
  assign sig_done         = r_done;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Scoreboard bench for frame_scan_controller: stimulus pushes expected
// pixel-pair beats, monitors pop and compare on every accepted beat.
module tb_frame_scan_controller;

  localparam int W   = 8;
  localparam int H   = 4;
  localparam int SD  = 3;
  localparam int HD  = 2;
  localparam int FT0 = SD + H * (HD + W / 2);   // 27
  localparam int W1  = 4;
  localparam int H1  = 2;
  localparam int FT1 = 1 + H1 * (1 + W1 / 2);   // 7
`ifdef FRAME_SCAN_ROW_FLIP_EN
  localparam bit FLIP = 1'b1;
`else
  localparam bit FLIP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        start, rd_ready, rd_valid, vertical_Pulse, horizontal_Pulse, busy, sig_done;
  logic [18:0] rd_addr;
  logic [9:0]  row;
  logic [10:0] column;
  logic        start1, rd_ready1, rd_valid1, vp1, hp1, busy1, done1;
  logic [18:0] rd_addr1;
  logic [9:0]  row1;
  logic [10:0] column1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int addr; int row; int col;} beat_t;
  beat_t q0[$];
  beat_t q1[$];
  beat_t mb0, mb1;

  frame_scan_controller #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .START_DELAY(SD),
                          .HSYNC_DELAY(HD), .ADDR_W(19)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .row(row), .column(column),
    .vertical_Pulse(vertical_Pulse), .horizontal_Pulse(horizontal_Pulse),
    .busy(busy), .sig_done(sig_done));

  frame_scan_controller #(.IMAGE_WIDTH(W1), .IMAGE_HEIGHT(H1), .START_DELAY(1),
                          .HSYNC_DELAY(1), .ADDR_W(19)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rd_ready(rd_ready1),
    .rd_valid(rd_valid1), .rd_addr(rd_addr1), .row(row1), .column(column1),
    .vertical_Pulse(vp1), .horizontal_Pulse(hp1),
    .busy(busy1), .sig_done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_addr(input int r, input int c, input int w, input int h);
    return (FLIP ? (h - 1 - r) : r) * w + c;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int which, input int w, input int h);
    beat_t b;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c += 2) begin
        b.addr = exp_addr(r, c, w, h);
        b.row  = r;
        b.col  = c;
        if (which == 0) q0.push_back(b);
        else            q1.push_back(b);
      end
    end
  endtask

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (rd_valid && rd_ready) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut0 unexpected beat: got addr %0d expected no beat", rd_addr);
      end else begin
        mb0 = q0.pop_front();
        check("dut0 addr", rd_addr, mb0.addr);
        check("dut0 row", row, mb0.row);
        check("dut0 column", column, mb0.col);
      end
    end
  end

  // Scoreboard monitor for the minimum-delay instance.
  always @(negedge clk) begin
    if (rd_valid1 && rd_ready1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut1 unexpected beat: got addr %0d expected no beat", rd_addr1);
      end else begin
        mb1 = q1.pop_front();
        check("dut1 addr", rd_addr1, mb1.addr);
        check("dut1 row", row1, mb1.row);
        check("dut1 column", column1, mb1.col);
      end
    end
  end

  // Push a frame and pulse (or hold) start; returns in the VSYNC entry cycle.
  task automatic start_frame(input bit hold);
    push_frame(0, W, H);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
  endtask

  // Runs from the VSYNC entry cycle to the DONE cycle, optionally stalling.
  task automatic run_body(input int stall_row, input int stall_col, input int stall_len,
                          input int start_at, input int exp_cycles, input string tag);
    int n, stalled, first_v, first_h;
    bit done_seen;
    n = 0; stalled = 0; first_v = -1; first_h = -1; done_seen = 1'b0;
    check({tag, " vsync busy"}, busy, 1);
    while (!done_seen && n < 400) begin
      if (vertical_Pulse && first_v < 0) first_v = n;
      if (horizontal_Pulse && first_h < 0) first_h = n;
      if (start_at >= 0) start = (n == start_at);
      if (rd_valid && row == 10'(stall_row) && column == 11'(stall_col) && stalled < stall_len) begin
        rd_ready = 1'b0;
        stalled++;
        check({tag, " stall hold addr"}, rd_addr, exp_addr(stall_row, stall_col, W, H));
      end else begin
        rd_ready = 1'b1;
      end
      if (sig_done) begin
        done_seen = 1'b1;
        check({tag, " frame time"}, n, exp_cycles);
      end else begin
        @(posedge clk); #1;
        n++;
      end
    end
    rd_ready = 1'b1;
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s frame timeout: got no sig_done expected at cycle %0d", tag, exp_cycles);
    end
    check({tag, " first vpulse"}, first_v, SD);
    check({tag, " first hpulse"}, first_h, SD + HD);
    check({tag, " stall cycles"}, stalled, stall_len);
  endtask

  // Cycle after DONE: back in IDLE with cleared position and no pending beats.
  task automatic post_done(input string tag);
    @(posedge clk); #1;
    check({tag, " done one cycle"}, sig_done, 0);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle row/col"}, {row, column}, 0);
    check({tag, " beats left"}, q0.size(), 0);
  endtask

  initial begin
    int n, cnt, fv, fh, fd;
    reset = 1'b1; start = 1'b0; rd_ready = 1'b1; start1 = 1'b0; rd_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {rd_valid, vertical_Pulse, horizontal_Pulse, busy, sig_done,
                            rd_addr, row, column}, 0);
    reset = 1'b0;

    // Plain frame, rd_ready high.
    start_frame(1'b0);
    run_body(-1, -1, 0, -1, FT0, "basic");
    post_done("basic");

    // Backpressure at row 1, column 4 for 5 cycles.
    start_frame(1'b0);
    run_body(1, 4, 5, -1, FT0 + 5, "stall");
    post_done("stall");

    // start pulsed in HSYNC is ignored.
    start_frame(1'b0);
    run_body(-1, -1, 0, SD, FT0, "hsync start");
    post_done("hsync start");
    cnt = 0;
    repeat (10) begin
      if (busy) cnt++;
      @(posedge clk); #1;
    end
    check("no second frame", cnt, 0);

    // start held high: DONE, IDLE, VSYNC.
    start_frame(1'b1);
    run_body(-1, -1, 0, -1, FT0, "held A");
    @(posedge clk); #1;
    check("held idle busy", busy, 0);
    push_frame(0, W, H);
    @(posedge clk); #1;
    check("held restart busy", busy, 1);
    start = 1'b0;
    run_body(-1, -1, 0, -1, FT0, "held B");
    post_done("held B");

    // Reset in DATA at row 2, then a full recovery frame.
    start_frame(1'b0);
    n = 0;
    while (!(rd_valid && row == 10'd2) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach row 2 in budget", (n < 200), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst outputs", {rd_valid, vertical_Pulse, horizontal_Pulse, busy, sig_done,
                             rd_addr, row, column}, 0);
    q0.delete();
    cnt = 0;
    repeat (40) begin
      if (sig_done) cnt++;
      @(posedge clk); #1;
    end
    check("midrst no done", cnt, 0);
    start_frame(1'b0);
    run_body(-1, -1, 0, -1, FT0, "recover");
    post_done("recover");

    // Minimum delays on the second instance.
    push_frame(1, W1, H1);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    fv = -1; fh = -1; fd = -1; n = 0;
    while (fd < 0 && n < 100) begin
      if (vp1 && fv < 0) fv = n;
      if (hp1 && fh < 0) fh = n;
      if (done1) fd = n;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("min vpulse rise", fv, 1);
    check("min hpulse rise", fh, 2);
    check("min frame time", fd, FT1);
    @(posedge clk); #1;
    check("min idle busy", busy1, 0);
    check("min beats left", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
